// File: rtl/telemetry_framer.sv
// Buffers 16-bit telemetry words and frames them as HEADER, len, data (MSB first), checksum.
// Latency: header start one cycle after trigger in IDLE; each byte waits for a full busy rise/fall before the next.
module telemetry_framer #(
    parameter int         FRAME_WORDS = 4,
    parameter int         FIFO_DEPTH  = 8,
    parameter logic [7:0] HEADER      = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic        flush,
    output logic        full,
    output logic        overflow,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        frame_active
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_LEN, S_DHI, S_DLO, S_CSUM} state_t;
    typedef enum logic [1:0] {P_ISSUE, P_WAIT_HI, P_WAIT_LO} phase_t;

    state_t state, state_nxt;
    phase_t phase, phase_nxt;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [15:0]   head;
    logic          push, pop;

    logic [7:0]    len, wleft, csum, frame_len, cur_byte;
    logic          pend_flush, flush_req, has_words, trigger;
    logic          issue, start_frame, frame_done;

    // Word FIFO; a pop frees a slot in the same cycle, so push-while-full succeeds when popping.
    assign full = (count == CW'(FIFO_DEPTH));
    assign push = wr_en && (!full || pop);
    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= wr_en && !push;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign flush_req = flush || pend_flush;
    assign has_words = (count != '0);
    assign trigger   = (count >= CW'(FRAME_WORDS)) || (flush_req && has_words);
    assign frame_len = (count >= CW'(FRAME_WORDS)) ? 8'(FRAME_WORDS) : 8'(count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            phase <= P_ISSUE;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
        end
    end

    // The header is issued straight from IDLE, so HDR is entered already waiting for busy.
    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        if (state == S_IDLE) begin
            phase_nxt = P_ISSUE;
            if (trigger && !tx_busy) begin
                state_nxt = S_HDR;
                phase_nxt = P_WAIT_HI;
            end
        end else begin
            case (phase)
                P_ISSUE:   if (!tx_busy) phase_nxt = P_WAIT_HI;
                P_WAIT_HI: if (tx_busy)  phase_nxt = P_WAIT_LO;
                P_WAIT_LO: begin
                    if (!tx_busy) begin
                        phase_nxt = P_ISSUE;
                        case (state)
                            S_HDR:   state_nxt = S_LEN;
                            S_LEN:   state_nxt = S_DHI;
                            S_DHI:   state_nxt = S_DLO;
                            S_DLO:   state_nxt = (wleft != 8'd0) ? S_DHI : S_CSUM;
                            default: state_nxt = S_IDLE;
                        endcase
                    end
                end
                default:   phase_nxt = P_ISSUE;
            endcase
        end
    end

    always_comb begin
        issue    = 1'b0;
        cur_byte = HEADER;
        if (state == S_IDLE) begin
            issue = trigger && !tx_busy;
        end else if (phase == P_ISSUE && !tx_busy) begin
            issue = 1'b1;
            case (state)
                S_LEN:   cur_byte = len;
                S_DHI:   cur_byte = head[15:8];
                S_DLO:   cur_byte = head[7:0];
                S_CSUM:  cur_byte = csum;
                default: cur_byte = HEADER;
            endcase
        end
    end

    assign start_frame = issue && (state == S_IDLE);
    assign pop         = issue && (state == S_DLO);
    assign frame_done  = (state == S_CSUM) && (phase == P_WAIT_LO) && !tx_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_start     <= 1'b0;
            tx_data      <= 8'h00;
            len          <= 8'h00;
            wleft        <= 8'h00;
            csum         <= 8'h00;
            frame_active <= 1'b0;
            pend_flush   <= 1'b0;
        end else begin
            tx_start <= issue;
            if (issue) tx_data <= cur_byte;
            if (start_frame) begin
                len          <= frame_len;
                wleft        <= frame_len;
                csum         <= 8'h00;
                frame_active <= 1'b1;
            end else begin
                if (issue && (state inside {S_LEN, S_DHI, S_DLO})) csum <= csum + cur_byte;
                if (pop) wleft <= wleft - 1'b1;
                if (frame_done) frame_active <= 1'b0;
            end
            // A flush seen with an empty FIFO in IDLE is dropped; outside IDLE it waits for the next IDLE.
            if (state == S_IDLE) pend_flush <= !start_frame && flush_req && has_words;
            else if (flush)      pend_flush <= 1'b1;
        end
    end

endmodule

// File: tb/tb_telemetry_framer.sv
// Directed bench for telemetry_framer with a transmitter model that holds busy 10 cycles per byte.
module tb_telemetry_framer;
    logic        clk = 1'b0;
    logic        rst_n, wr_en, flush, full, overflow, tx_start, tx_busy, frame_active;
    logic [15:0] wr_data;
    logic [7:0]  tx_data;
    logic        model_busy, force_busy;
    logic        fa_prev = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ov_cnt = 0;

    logic [7:0] bytes[$];
    int         start_cyc[$];
    logic       start_fa[$];
    int         fall_cyc[$];

    assign tx_busy = model_busy | force_busy;

    telemetry_framer #(.FRAME_WORDS(4), .FIFO_DEPTH(8), .HEADER(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
        .full(full), .overflow(overflow), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .frame_active(frame_active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_start) begin
            bytes.push_back(tx_data);
            start_cyc.push_back(cyc);
            start_fa.push_back(frame_active);
        end
        if (overflow) ov_cnt++;
        if (fa_prev && !frame_active) fall_cyc.push_back(cyc);
        fa_prev = frame_active;
    end

    initial begin
        model_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                model_busy = 1'b1;
                repeat (10) @(negedge clk);
                model_busy = 1'b0;
            end
        end
    end

    task automatic push(input logic [15:0] d);
        wr_en = 1'b1; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < budget && !ok; t++) begin
            @(negedge clk); #1;
            if (bytes.size() >= n) ok = 1'b1;
        end
    endtask

    task automatic wait_frame(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < budget && !ok; t++) begin
            @(negedge clk); #1;
            if (bytes.size() >= n && !frame_active && !tx_busy) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL reset_frame_active: got %b want 0", frame_active); end
    endtask

    task automatic test_full_frame();
        logic [7:0] exp_b [11];
        int base, c_push;
        bit ok, fa_ok;
        exp_b = '{8'hA5, 8'h04, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hFF, 8'h00, 8'hC2};
        base = bytes.size();
        push(16'h1234); push(16'hABCD); push(16'h0001); push(16'hFF00);
        c_push = cyc;
        wait_frame(base + 11, 1000, ok);
        checks++;
        if (!ok || bytes.size() != base + 11) begin
            errors++; $display("FAIL full_count: got %0d bytes want 11", bytes.size() - base);
        end else begin
            for (int i = 0; i < 11; i++) begin
                checks++;
                if (bytes[base+i] !== exp_b[i]) begin
                    errors++; $display("FAIL full_byte%0d: got %h want %h", i, bytes[base+i], exp_b[i]);
                end
            end
            checks++;
            if (start_cyc[base] - c_push !== 1) begin
                errors++; $display("FAIL full_hdr_latency: got %0d want 1", start_cyc[base] - c_push);
            end
            fa_ok = 1'b1;
            for (int i = 0; i < 11; i++) if (start_fa[base+i] !== 1'b1) fa_ok = 1'b0;
            checks++; if (!fa_ok) begin errors++; $display("FAIL full_frame_active_span: got low during frame want high"); end
        end
        checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL full_frame_active_end: got %b want 0", frame_active); end
        repeat (20) @(negedge clk);
        checks++; if (bytes.size() != base + 11) begin errors++; $display("FAIL full_extra_bytes: got %0d want 11", bytes.size() - base); end
    endtask

    task automatic test_flush_short();
        logic [7:0] exp_b [5];
        int base;
        bit ok;
        exp_b = '{8'hA5, 8'h01, 8'h00, 8'hFF, 8'h00};
        base = bytes.size();
        push(16'h00FF);
        repeat (15) @(negedge clk);
        checks++; if (bytes.size() != base) begin errors++; $display("FAIL short_no_early_frame: got %0d bytes want 0", bytes.size() - base); end
        pulse_flush();
        wait_frame(base + 5, 1000, ok);
        checks++;
        if (!ok || bytes.size() != base + 5) begin
            errors++; $display("FAIL short_count: got %0d bytes want 5", bytes.size() - base);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (bytes[base+i] !== exp_b[i]) begin
                    errors++; $display("FAIL short_byte%0d: got %h want %h", i, bytes[base+i], exp_b[i]);
                end
            end
        end
    endtask

    task automatic test_flush_empty();
        int base;
        base = bytes.size();
        pulse_flush();
        repeat (40) @(negedge clk);
        checks++; if (bytes.size() != base) begin errors++; $display("FAIL empty_flush: got %0d bytes want 0", bytes.size() - base); end
        checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL empty_flush_active: got %b want 0", frame_active); end
    endtask

    task automatic test_overflow();
        int base, ovb;
        base = bytes.size();
        ovb  = ov_cnt;
        force_busy = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            push(16'(32'h1111 * (i + 1)));
            if (i == 6) begin
                checks++; if (full !== 1'b0) begin errors++; $display("FAIL ovf_full_at7: got %b want 0", full); end
            end
            if (i == 7) begin
                checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full_at8: got %b want 1", full); end
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_pulse_at8: got %b want 0", overflow); end
            end
            if (i == 8) begin
                checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse_at9: got %b want 1", overflow); end
            end
        end
        repeat (20) @(negedge clk);
        checks++; if (ov_cnt - ovb != 1) begin errors++; $display("FAIL ovf_pulse_count: got %0d want 1", ov_cnt - ovb); end
        checks++; if (bytes.size() != base) begin errors++; $display("FAIL ovf_start_while_busy: got %0d bytes want 0", bytes.size() - base); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full_hold: got %b want 1", full); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [22];
        int base, fb;
        bit ok;
        exp_b = '{8'hA5, 8'h04, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44, 8'h58,
                  8'hA5, 8'h04, 8'h55, 8'h55, 8'h66, 8'h66, 8'h77, 8'h77, 8'h88, 8'h88, 8'h78};
        base = bytes.size();
        fb   = fall_cyc.size();
        force_busy = 1'b0;
        wait_frame(base + 22, 3000, ok);
        checks++;
        if (!ok || bytes.size() != base + 22 || fall_cyc.size() < fb + 2) begin
            errors++; $display("FAIL b2b_count: got %0d bytes want 22", bytes.size() - base);
        end else begin
            for (int i = 0; i < 22; i++) begin
                checks++;
                if (bytes[base+i] !== exp_b[i]) begin
                    errors++; $display("FAIL b2b_byte%0d: got %h want %h", i, bytes[base+i], exp_b[i]);
                end
            end
            checks++;
            if (start_cyc[base+11] - fall_cyc[fb] !== 1) begin
                errors++; $display("FAIL b2b_gap: got %0d cycles want 1", start_cyc[base+11] - fall_cyc[fb]);
            end
        end
        repeat (40) @(negedge clk);
        checks++; if (bytes.size() != base + 22) begin errors++; $display("FAIL b2b_dropped_word_sent: got %0d bytes want 22", bytes.size() - base); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL b2b_full_end: got %b want 0", full); end
    endtask

    task automatic test_flush_mid_frame();
        logic [7:0] exp_b [18];
        int base;
        bit ok;
        exp_b = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h28,
                  8'hA5, 8'h02, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h30};
        base = bytes.size();
        push(16'h0102); push(16'h0304); push(16'h0506); push(16'h0708);
        wait_bytes(base + 1, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_first_header: got no header want header"); end
        push(16'h0A0B); push(16'h0C0D);
        pulse_flush();
        wait_frame(base + 18, 3000, ok);
        checks++;
        if (!ok || bytes.size() != base + 18) begin
            errors++; $display("FAIL mid_count: got %0d bytes want 18", bytes.size() - base);
        end else begin
            for (int i = 0; i < 18; i++) begin
                checks++;
                if (bytes[base+i] !== exp_b[i]) begin
                    errors++; $display("FAIL mid_byte%0d: got %h want %h", i, bytes[base+i], exp_b[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] exp_b [5];
        int base, sb;
        bit ok;
        exp_b = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h06};
        base = bytes.size();
        for (int i = 0; i < 8; i++) push(16'hDE00 + 16'(i));
        wait_bytes(base + 3, 500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_mid_third_byte: got %0d bytes want 3", bytes.size() - base); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL rst_mid_full_before: got %b want 1", full); end
        rst_n = 1'b0;
        #1;
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rst_mid_tx_start: got %b want 0", tx_start); end
        checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL rst_mid_frame_active: got %b want 0", frame_active); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_mid_full: got %b want 0", full); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_mid_tx_data: got %h want 00", tx_data); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        sb = bytes.size();
        repeat (60) @(negedge clk);
        checks++; if (bytes.size() != sb) begin errors++; $display("FAIL rst_mid_resume: got %0d bytes want 0", bytes.size() - sb); end
        push(16'h0203);
        pulse_flush();
        wait_frame(sb + 5, 1000, ok);
        checks++;
        if (!ok || bytes.size() != sb + 5) begin
            errors++; $display("FAIL rst_mid_new_count: got %0d bytes want 5", bytes.size() - sb);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (bytes[sb+i] !== exp_b[i]) begin
                    errors++; $display("FAIL rst_mid_new_byte%0d: got %h want %h", i, bytes[sb+i], exp_b[i]);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_data = 16'h0000; flush = 1'b0; force_busy = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_full_frame();
        test_flush_short();
        test_flush_empty();
        test_overflow();
        test_back_to_back();
        test_flush_mid_frame();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
